// File: rtl/reg_file_pkg.sv
// Shared types and constants for the banked register file.
// Mode encoding, physical sizing and the init/run state machine encoding.
package reg_file_pkg;

  typedef enum logic [1:0] {
    USR = 2'd0,
    FIQ = 2'd1,
    IRQ = 2'd2,
    SVC = 2'd3
  } mode_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int          NUM_PHYS = 21;
  localparam logic [3:0]  PC_IDX   = 4'd15;
  localparam logic [4:0]  R13_BASE = 5'd13;
  localparam logic [4:0]  R14_BASE = 5'd17;

endpackage

// File: rtl/reg_file_map.sv
// Logical (mode, index) to physical entry translation.
// R13/R14 fan out into four per-mode copies; index 15 has no storage.
module reg_file_map
  import reg_file_pkg::*;
(
  input  mode_e      mode,
  input  logic [3:0] idx,
  output logic [4:0] phys,
  output logic       valid
);

  always_comb begin
    phys  = {1'b0, idx};
    valid = (idx != PC_IDX);
    if (idx == 4'd13) phys = R13_BASE + {3'b000, mode};
    else if (idx == 4'd14) phys = R14_BASE + {3'b000, mode};
  end

endmodule

// File: rtl/reg_file_banked.sv
// Banked register file: shared R0-R12, per-mode R13/R14, external R15.
// Storage is zeroed by a one-entry-per-cycle sweep after reset or clr_req.
module reg_file_banked
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     mode,
  input  logic                           we,
  input  logic [3:0]                     wa,
  input  logic [DATA_W-1:0]              wd,
  input  logic [NUM_RD-1:0][3:0]         ra,
  input  logic [DATA_W-1:0]              r15,
  input  logic                           clr_req,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
  output logic                           ready
);

  state_e            state;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] mem [NUM_PHYS];

  mode_e       cur_mode;
  logic [4:0]  w_phys;
  logic        w_valid;
  logic        wr_en;

  assign cur_mode = mode_e'(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == 5'(NUM_PHYS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        RUN: begin
          if (clr_req) begin
            state <= INIT;
            ready <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  reg_file_map u_wmap (
    .mode  (cur_mode),
    .idx   (wa),
    .phys  (w_phys),
    .valid (w_valid)
  );

  assign wr_en = we && ready && w_valid;

  // No reset on the array so it can map onto RAM; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt] <= '0;
    else if (wr_en)    mem[w_phys] <= wd;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [4:0] r_phys;
    logic       r_valid;

    reg_file_map u_rmap (
      .mode  (cur_mode),
      .idx   (ra[p]),
      .phys  (r_phys),
      .valid (r_valid)
    );

    always_comb begin
      rd[p] = '0;
      if (ready) begin
        if (!r_valid)                                   rd[p] = r15;
        else if (BYPASS != 0 && wr_en && r_phys == w_phys) rd[p] = wd;
        else                                            rd[p] = mem[r_phys];
      end
    end
  end

endmodule

// File: doc/reg_file_banked.md
REG_FILE_BANKED -- requirements
Module: reg_file_banked

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter NUM_RD, default 3, number of independent read ports (1..4).
REQ-003 Parameter BYPASS, default 1, write-to-read forwarding (1 = enabled).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 mode  in  2  processor mode: USR, FIQ, IRQ or SVC.
REQ-007 we  in  1  write enable.
REQ-008 wa  in  4  write register index.
REQ-009 wd  in  DATA_W  write data.
REQ-010 ra  in  NUM_RD x 4  read register index per port.
REQ-011 r15  in  DATA_W  externally supplied PC value, returned for index 15.
REQ-012 clr_req  in  1  request full register clear.
REQ-013 rd  out  NUM_RD x DATA_W  read data per port.
REQ-014 ready  out  1  file initialised and accepting writes.

Function
REQ-015 Physical storage: R0-R12 shared; R13, R14 have one copy each for USR, FIQ, IRQ and SVC; 21 entries total.
REQ-016 R15 has no storage; a read of index 15 returns r15 combinationally; a write to index 15 is discarded.
REQ-017 Logical R13/R14 map to the bank selected by the current mode, for both reads and writes.
REQ-018 Reads are combinational, zero latency; all ports are independent, and equal indices on several ports are legal.
REQ-019 Write commits at the rising edge when we=1, ready=1 and wa!=15.
REQ-020 With BYPASS=1, a read whose index matches a committing write in the same mode returns wd in that cycle; with BYPASS=0 it returns the old value.
REQ-021 FSM states: INIT and RUN.
REQ-022 INIT: an internal 5-bit sweep counter writes 0 to one physical entry per cycle, 0 to 20; it leaves INIT after entry 20 is written.
REQ-023 INIT -> RUN after exactly 21 cycles; ready rises on the cycle RUN is entered.
REQ-024 In RUN, clr_req=1 -> INIT with the counter at 0 on the next edge; clr_req is ignored while in INIT.
REQ-025 In INIT: ready=0, we is ignored, and every rd port returns 0, including index 15.
REQ-026 A simultaneous we and clr_req in RUN: the write commits, then INIT clears it.
REQ-027 A mode change takes effect on reads immediately; a write uses the mode sampled at the committing edge.

Reset
REQ-028 rst_n low forces state INIT, counter 0 and ready 0 asynchronously; rd reads 0.
REQ-029 Storage entries are not reset directly; they are cleared only by the INIT sweep.
REQ-030 Assertion of rst_n during an INIT sweep restarts the sweep from entry 0.
REQ-031 Release of rst_n is synchronised by the integrator; the block requires only that release is clean w.r.t. clk.

Structure
REQ-032 Shared package reg_file_pkg holds: mode enum (USR=0, FIQ=1, IRQ=2, SVC=3), PC_IDX=15, NUM_PHYS=21, and the FSM state enum.
REQ-033 Sub-module reg_file_map is natural: combinational (mode, index) -> physical-entry translation, instantiated once per read port plus once for the write port.
REQ-034 Storage is a flat 21 x DATA_W array with no reset, suitable for RAM inference.

Verification
REQ-035 Reset release -> ready=0 for 21 cycles and ready=1 on cycle 21; every index 0-14 then reads 0.
REQ-036 USR write R0=0x000000FF, then read port 0 at R0 -> 0x000000FF; r15=0x14 with ra=15 -> 0x14.
REQ-037 USR write R13=0x1000, switch to IRQ, write R13=0x2000 -> IRQ reads 0x2000 and USR reads 0x1000.
REQ-038 BYPASS=1: we=1, wa=3, wd=0xF, ra[1]=3 in the same cycle -> rd[1]=0xF before the edge; BYPASS=0 -> 0.
REQ-039 Write R1=0xF0, then clr_req=1 -> ready=0 for 21 cycles and R1 reads 0 afterwards; writes during INIT are lost.
REQ-040 rst_n low at cycle 10 of a sweep -> the sweep restarts and ready rises 21 cycles after release; a write to index 15 leaves all entries unchanged.
